// File: rtl/clock_pkg.sv
// Shared constants and types for the time-of-day core: segment patterns,
// BCD limits and the load-port state encoding.
package clock_pkg;

  // Segment patterns, bit 6 = g ... bit 0 = a, active-high.
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [7:0] BCD_MAX_SEC  = 8'h59;
  localparam logic [7:0] BCD_MAX_MIN  = 8'h59;
  localparam logic [7:0] BCD_MAX_HOUR = 8'h23;

  typedef enum logic {
    LOAD_IDLE  = 1'b0,
    LOAD_CHECK = 1'b1
  } load_state_t;

  // Once both nibbles are decimal, packed BCD orders like the number it encodes.
  function automatic logic bcd_in_range(input logic [7:0] value, input logic [7:0] max);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
  endfunction

endpackage

// File: rtl/bcd_seg7.sv
// One BCD digit to seven-segment pattern; non-decimal codes blank the digit.
module bcd_seg7
  import clock_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  logic [6:0] seg_on;

  always_comb begin
    case (bcd)
      4'd0:    seg_on = SEG_0;
      4'd1:    seg_on = SEG_1;
      4'd2:    seg_on = SEG_2;
      4'd3:    seg_on = SEG_3;
      4'd4:    seg_on = SEG_4;
      4'd5:    seg_on = SEG_5;
      4'd6:    seg_on = SEG_6;
      4'd7:    seg_on = SEG_7;
      4'd8:    seg_on = SEG_8;
      4'd9:    seg_on = SEG_9;
      default: seg_on = SEG_OFF;
    endcase
  end

  assign seg = ACTIVE_LOW ? ~seg_on : seg_on;

endmodule

// File: rtl/clock_core.sv
// Single-clock time-of-day core: prescaled second tick, 24-hour BCD time,
// checked load port and 12/24-hour seven-segment display.
//
// state      | meaning
// LOAD_IDLE  | load port ready, waiting for set_valid
// LOAD_CHECK | shadow value under range check; commit or reject this cycle
module clock_core
  import clock_pkg::*;
#(
  parameter int TICK_DIV       = 50_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       inclk,
  input  logic       rst,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  output logic       set_err,
  output logic       sec_tick,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       pm,
  output logic [6:0] sec_seg1,
  output logic [6:0] sec_seg10,
  output logic [6:0] min_seg1,
  output logic [6:0] min_seg10,
  output logic [6:0] hour_seg1,
  output logic [6:0] hour_seg10
);

  localparam int                PCNT_W    = $clog2(TICK_DIV);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);

  load_state_t       state, next_state;
  logic [PCNT_W-1:0] pcnt;
  logic [7:0]        shd_hh, shd_mm, shd_ss;
  logic [3:0]        sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
  logic              advance, commit, reject, load_ok;
  logic              sec_lo_wrap, sec_wrap, min_lo_wrap, min_wrap, hour_wrap;
  logic [7:0]        hour_store;
  logic [4:0]        hour_bin, hour_12;

  assign advance = run && (pcnt == PCNT_LAST);
  assign load_ok = bcd_in_range(shd_hh, BCD_MAX_HOUR) &&
                   bcd_in_range(shd_mm, BCD_MAX_MIN) &&
                   bcd_in_range(shd_ss, BCD_MAX_SEC);

  always_ff @(posedge inclk or negedge rst) begin
    if (!rst) state <= LOAD_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD_IDLE:  if (set_valid) next_state = LOAD_CHECK;
      LOAD_CHECK: next_state = LOAD_IDLE;
      default:    next_state = LOAD_IDLE;
    endcase
  end

  always_comb begin
    set_ready = 1'b0;
    commit    = 1'b0;
    reject    = 1'b0;
    case (state)
      LOAD_IDLE:  set_ready = 1'b1;
      LOAD_CHECK: begin
        commit = load_ok;
        reject = !load_ok;
      end
      default:    set_ready = 1'b0;
    endcase
  end

  always_ff @(posedge inclk or negedge rst) begin
    if (!rst) begin
      shd_hh <= 8'h00;
      shd_mm <= 8'h00;
      shd_ss <= 8'h00;
    end else if (set_valid && set_ready) begin
      shd_hh <= set_hh;
      shd_mm <= set_mm;
      shd_ss <= set_ss;
    end
  end

  // A commit restarts the second, so it also swallows any advance on the same edge.
  always_ff @(posedge inclk or negedge rst) begin
    if (!rst)                   pcnt <= '0;
    else if (commit || advance) pcnt <= '0;
    else if (run)               pcnt <= pcnt + PCNT_W'(1);
  end

  assign sec_lo_wrap = (sec_lo == 4'd9);
  assign sec_wrap    = sec_lo_wrap && (sec_hi == BCD_MAX_SEC[7:4]);
  assign min_lo_wrap = (min_lo == 4'd9);
  assign min_wrap    = min_lo_wrap && (min_hi == BCD_MAX_MIN[7:4]);
  assign hour_wrap   = (hr_hi == BCD_MAX_HOUR[7:4]) && (hr_lo == BCD_MAX_HOUR[3:0]);

  always_ff @(posedge inclk or negedge rst) begin
    if (!rst) begin
      {sec_hi, sec_lo} <= 8'h00;
      {min_hi, min_lo} <= 8'h00;
      {hr_hi, hr_lo}   <= 8'h00;
    end else if (commit) begin
      {sec_hi, sec_lo} <= shd_ss;
      {min_hi, min_lo} <= shd_mm;
      {hr_hi, hr_lo}   <= shd_hh;
    end else if (advance) begin
      sec_lo <= sec_lo_wrap ? 4'd0 : sec_lo + 4'd1;
      if (sec_lo_wrap) sec_hi <= sec_wrap ? 4'd0 : sec_hi + 4'd1;
      if (sec_wrap) min_lo <= min_lo_wrap ? 4'd0 : min_lo + 4'd1;
      if (sec_wrap && min_lo_wrap) min_hi <= min_wrap ? 4'd0 : min_hi + 4'd1;
      if (sec_wrap && min_wrap) begin
        if (hour_wrap) begin
          hr_hi <= 4'd0;
          hr_lo <= 4'd0;
        end else if (hr_lo == 4'd9) begin
          hr_hi <= hr_hi + 4'd1;
          hr_lo <= 4'd0;
        end else begin
          hr_lo <= hr_lo + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge inclk or negedge rst) begin
    if (!rst) begin
      sec_tick <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      sec_tick <= advance && !commit;
      set_err  <= reject;
    end
  end

  assign hour_store = {hr_hi, hr_lo};
  assign sec_bcd    = {sec_hi, sec_lo};
  assign min_bcd    = {min_hi, min_lo};
  assign pm         = (hour_store >= 8'h12);

  always_comb begin
    hour_bin = 5'(hr_hi) * 5'd10 + 5'(hr_lo);
    hour_12  = 5'd0;
    hour_bcd = hour_store;
    if (mode_12h) begin
      if (hour_bin == 5'd0) begin
        hour_bcd = 8'h12;
      end else if (hour_bin > 5'd12) begin
        hour_12  = hour_bin - 5'd12;
        hour_bcd = (hour_12 >= 5'd10) ? {4'd1, 4'(hour_12 - 5'd10)} : {4'd0, hour_12[3:0]};
      end
    end
  end

  bcd_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_sec_seg1   (.bcd(sec_lo),         .seg(sec_seg1));
  bcd_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_sec_seg10  (.bcd(sec_hi),         .seg(sec_seg10));
  bcd_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_min_seg1   (.bcd(min_lo),         .seg(min_seg1));
  bcd_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_min_seg10  (.bcd(min_hi),         .seg(min_seg10));
  bcd_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hour_seg1  (.bcd(hour_bcd[3:0]),  .seg(hour_seg1));
  bcd_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hour_seg10 (.bcd(hour_bcd[7:4]),  .seg(hour_seg10));

endmodule

// File: tb/tb_clock_core.sv
// Scoreboard bench for clock_core: a seconds-of-day model predicts ticks and
// load outcomes, and a negedge monitor checks them as the DUT presents them.
module tb_clock_core;

  localparam int TICK_DIV = 4;
  localparam int HALF     = 5;

  logic       inclk = 1'b0;
  logic       rst, run, mode_12h, set_valid;
  logic [7:0] set_hh, set_mm, set_ss;
  logic       set_ready, set_err, sec_tick, pm;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [6:0] sec_seg1, sec_seg10, min_seg1, min_seg10, hour_seg1, hour_seg10;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    longint stamp;
    int     secs;
    bit     err;
  } exp_t;

  exp_t tick_q[$];
  exp_t load_q[$];

  int         m_secs, m_pcnt;
  bit         m_busy, m_adv, m_committed, m_finish, m_load_err;
  logic [7:0] m_hh, m_mm, m_ss;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  clock_core #(.TICK_DIV(TICK_DIV), .SEG_ACTIVE_LOW(1'b0)) dut (
    .inclk(inclk), .rst(rst), .run(run), .mode_12h(mode_12h),
    .set_valid(set_valid), .set_ready(set_ready),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_err(set_err),
    .sec_tick(sec_tick), .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .pm(pm),
    .sec_seg1(sec_seg1), .sec_seg10(sec_seg10), .min_seg1(min_seg1), .min_seg10(min_seg10),
    .hour_seg1(hour_seg1), .hour_seg10(hour_seg10)
  );

  always #HALF inclk = ~inclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [7:0] v, input int lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bcd2int(v) < lim);
  endfunction

  task automatic chk_time(input string name, input int secs);
    int h, m, s, dh;
    h  = secs / 3600;
    m  = (secs / 60) % 60;
    s  = secs % 60;
    dh = mode_12h ? (((h % 12) == 0) ? 12 : (h % 12)) : h;
    chk({name, "_time"}, {hour_bcd, min_bcd, sec_bcd, pm}, {to_bcd(dh), to_bcd(m), to_bcd(s), (h >= 12)});
    chk({name, "_seg"},
        {hour_seg10, hour_seg1, min_seg10, min_seg1, sec_seg10, sec_seg1},
        {seg_tab[dh / 10], seg_tab[dh % 10], seg_tab[m / 10], seg_tab[m % 10], seg_tab[s / 10], seg_tab[s % 10]});
  endtask

  // Reference model: time as seconds since midnight, prescaler as a plain count.
  always @(posedge inclk or negedge rst) begin
    if (!rst) begin
      m_secs = 0;
      m_pcnt = 0;
      m_busy = 1'b0;
    end else begin
      m_adv       = run && (m_pcnt == TICK_DIV - 1);
      m_committed = 1'b0;
      m_finish    = 1'b0;
      m_load_err  = 1'b0;
      if (m_busy) begin
        m_busy   = 1'b0;
        m_finish = 1'b1;
        if (bcd_ok(m_hh, 24) && bcd_ok(m_mm, 60) && bcd_ok(m_ss, 60)) begin
          m_secs      = bcd2int(m_hh) * 3600 + bcd2int(m_mm) * 60 + bcd2int(m_ss);
          m_pcnt      = 0;
          m_committed = 1'b1;
        end else begin
          m_load_err = 1'b1;
        end
      end else if (set_valid) begin
        m_hh   = set_hh;
        m_mm   = set_mm;
        m_ss   = set_ss;
        m_busy = 1'b1;
      end
      if (!m_committed) begin
        if (m_adv) begin
          m_pcnt = 0;
          m_secs = (m_secs + 1) % 86400;
          tick_q.push_back(exp_t'{stamp: $time, secs: m_secs, err: 1'b0});
        end else if (run) begin
          m_pcnt = m_pcnt + 1;
        end
      end
      if (m_finish) load_q.push_back(exp_t'{stamp: $time, secs: m_secs, err: m_load_err});
    end
  end

  bit   prev_ready = 1'b1;
  int   low_cnt    = 0;
  exp_t mon_e;

  always @(negedge inclk) begin
    if (!rst) begin
      prev_ready = 1'b1;
      low_cnt    = 0;
    end else begin
      if (sec_tick) begin
        if (tick_q.size() == 0) begin
          chk("tick_unexpected", 1, 0);
        end else begin
          mon_e = tick_q.pop_front();
          chk("tick_edge", 64'($time - HALF), 64'(mon_e.stamp));
          chk_time("tick", mon_e.secs);
        end
      end
      if (set_ready && !prev_ready) begin
        if (load_q.size() == 0) begin
          chk("load_unexpected", 1, 0);
        end else begin
          mon_e = load_q.pop_front();
          chk("load_edge", 64'($time - HALF), 64'(mon_e.stamp));
          chk("load_err", set_err, mon_e.err);
          chk("ready_low_cycles", low_cnt, 1);
          chk_time("load", mon_e.secs);
        end
      end else if (set_err) begin
        chk("set_err_spurious", set_err, 1'b0);
      end
      low_cnt    = set_ready ? 0 : low_cnt + 1;
      prev_ready = set_ready;
    end
  end

  task automatic step();
    @(posedge inclk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
    set_hh    = hh;
    set_mm    = mm;
    set_ss    = ss;
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    step();
  endtask

  initial begin
    int waited;
    rst = 1'b0; run = 1'b0; mode_12h = 1'b0; set_valid = 1'b0;
    set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00;
    repeat (3) step();
    chk("rst_ready", set_ready, 1'b1);
    chk("rst_tick", sec_tick, 1'b0);
    chk("rst_err", set_err, 1'b0);
    chk_time("rst", 0);
    mode_12h = 1'b1;
    #1;
    chk("rst_hour_12h", hour_bcd, 8'h12);
    chk_time("rst_12h", 0);
    mode_12h = 1'b0;

    rst = 1'b1;
    run = 1'b1;
    repeat (12) step();
    chk("sec_after_12", sec_bcd, 8'h03);
    chk("seg1_after_12", sec_seg1, 7'h4F);

    run = 1'b0;
    do_load(8'h23, 8'h59, 8'h59);
    chk_time("load_235959", 86399);
    run = 1'b1;
    repeat (TICK_DIV) step();
    chk_time("rollover", 0);
    chk("rollover_tick", sec_tick, 1'b1);

    run = 1'b0;
    do_load(8'h13, 8'h05, 8'h00);
    mode_12h = 1'b1;
    #1;
    chk("h13_12h_hour", hour_bcd, 8'h01);
    chk("h13_12h_pm", pm, 1'b1);
    mode_12h = 1'b0;
    #1;
    chk("h13_24h_hour", hour_bcd, 8'h13);

    do_load(8'h24, 8'h00, 8'h00);
    do_load(8'h12, 8'h60, 8'h00);
    do_load(8'h00, 8'h00, 8'h1A);
    chk_time("after_rejects", 13 * 3600 + 5 * 60);

    // Line up the check edge with an advance edge.
    run    = 1'b1;
    waited = 0;
    while (!(m_pcnt == TICK_DIV - 2 && !m_busy) && waited < 20) begin
      step();
      waited++;
    end
    chk("collide_align_timeout", waited < 20, 1'b1);
    do_load(8'h08, 8'h30, 8'h15);
    chk_time("collide", 8 * 3600 + 30 * 60 + 15);
    chk("collide_no_tick", sec_tick, 1'b0);
    repeat (TICK_DIV + 1) step();

    step();
    run = 1'b0;
    repeat (10) step();
    chk_time("hold", m_secs);
    run = 1'b1;
    repeat (2 * TICK_DIV) step();

    for (int i = 0; i < 400; i++) begin
      step();
      if ((i % 8) == 0) chk_time("rand", m_secs);
      run       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode_12h = ~mode_12h;
      set_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        set_hh = to_bcd($urandom_range(0, 23));
        set_mm = to_bcd($urandom_range(0, 59));
        set_ss = to_bcd($urandom_range(0, 59));
      end else begin
        set_hh = 8'($urandom);
        set_mm = 8'($urandom);
        set_ss = 8'($urandom);
      end
    end
    set_valid = 1'b0;
    run       = 1'b0;
    repeat (3) step();

    do_load(8'h10, 8'h20, 8'h30);
    set_hh    = 8'h11;
    set_mm    = 8'h11;
    set_ss    = 8'h11;
    set_valid = 1'b1;
    step();
    rst       = 1'b0;
    set_valid = 1'b0;
    #1;
    chk("rst_check_ready", set_ready, 1'b1);
    chk("rst_check_err", set_err, 1'b0);
    chk_time("rst_check", 0);
    repeat (3) step();
    chk_time("rst_check_hold", 0);
    rst = 1'b1;
    repeat (3) step();
    chk_time("rst_no_commit", 0);
    chk("tick_q_empty", tick_q.size(), 0);
    chk("load_q_empty", load_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_core.md
# clock_core

Parametrised single-clock time-of-day core: an internal prescaler derives a one-second tick from `inclk`, BCD counters keep HH:MM:SS, and six seven-segment digit outputs are decoded. A valid/ready load port sets the time with range checking. Pins select 12/24-hour display and freeze or run the clock. It replaces the three-clock divider-plus-segment-counter arrangement and sits directly under the board top level.

## Interface
- `TICK_DIV`, default 50_000_000: `inclk` cycles per second tick; must be ≥ 2.
- `SEG_ACTIVE_LOW`, default 0: 1 inverts all segment outputs.
- `inclk`  in  1  system clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `run`  in  1  1 = prescaler and time advance; 0 = both hold.
- `mode_12h`  in  1  display select; affects outputs only, never the stored time.
- `set_valid`  in  1  load request.
- `set_ready`  out  1  load port can accept.
- `set_hh`, `set_mm`, `set_ss`  in  8 each  packed BCD load value, 24-hour form.
- `set_err`  out  1  one-cycle pulse when a load value is rejected.
- `sec_tick`  out  1  one-cycle pulse, coincident with each new time value.
- `hour_bcd`, `min_bcd`, `sec_bcd`  out  8 each  displayed time, packed BCD.
- `pm`  out  1  stored hour ≥ 12, in either mode.
- `sec_seg1`, `sec_seg10`, `min_seg1`, `min_seg10`, `hour_seg1`, `hour_seg10`  out  7 each  segments. Bit 6 = g … bit 0 = a.

## Operation
- Prescaler `pcnt` counts 0..TICK_DIV-1 while `run`=1.
  - Advance condition: the edge where `run`=1 and `pcnt`=TICK_DIV-1.
  - On that edge, `pcnt`←0, seconds increment and carry ripples: ss 59→00 carries to mm, mm 59→00 carries to hh, hh 23→00.
  - All six digits update on the same edge.
- Stored time is always 24-hour BCD. Each digit is an independent 4-bit counter with per-digit terminal values.
- 12-hour display:
  - stored 00 → 12;
  - 01–12 → unchanged;
  - 13–23 → stored hour minus 12, in BCD.
  - Leading zero is shown as "0", not blanked.
- Load FSM, IDLE and CHECK:
  - IDLE: `set_ready`=1. `set_valid`&&`set_ready` captures `set_*` into shadow registers, then → CHECK.
  - CHECK: `set_ready`=0. Valid value means every nibble ≤ 9, hh ≤ 0x23, mm ≤ 0x59, ss ≤ 0x59.
  - CHECK, valid value: commit the time, `pcnt`←0, no `sec_tick`, → IDLE.
  - CHECK, invalid value: pulse `set_err`, time untouched, → IDLE.
  - Commit occurs regardless of `run`.
- Collision: an advance edge that coincides with a CHECK commit is discarded; commit wins. On reject, the advance proceeds normally.
- `set_valid` is ignored while `set_ready`=0.

## Timing
- Reset values: time 00:00:00, `pcnt` 0, FSM IDLE, `set_ready` 1, `set_err` 0, `sec_tick` 0, `pm` 0.
  - `hour_bcd` resets to 0x00, or 0x12 when `mode_12h`=1.
  - Segment outputs reset to digit "0" (0x3F, or 0x40 if active-low), except 12-hour hour digits showing "1","2".
- `sec_tick`, the BCD time registers and `set_err` are registered. `sec_tick` is high in the cycle the new time first appears.
- Display outputs are combinational from stored time and `mode_12h`: zero-cycle latency from the time registers, one cycle after the advance or commit edge.
- Load latency: accept edge → commit or reject edge one cycle later. Next accept is possible two cycles after the previous one.
- `run` falling mid-second: `pcnt` holds its value and resumes from it.
- Reset asserted mid-operation clears everything immediately, including a pending CHECK. No commit occurs.

## Structure
- Package `clock_pkg`:
  - seven-segment digit constants `SEG_0`..`SEG_9`;
  - BCD limit constants `BCD_MAX_SEC`, `BCD_MAX_MIN`, `BCD_MAX_HOUR`;
  - FSM state typedef `load_state_t`.
- One sub-module, `bcd_seg7`: a 4-bit BCD to 7-bit segment decoder with an active-low parameter. It is instanced six times; codes above 9 decode to all segments off.
- Prescaler, counters, 12-hour mapping and load FSM stay in `clock_core`.

## Test plan
- Reset, then `TICK_DIV`=4 with `run`=1: `sec_tick` every 4 cycles. After 12 cycles `sec_bcd`=0x03 and `sec_seg1`=0x4F.
- Load 23:59:59 then run one second: output 00:00:00, `pm` 0→… goes from 1 to 0, single `sec_tick`. All six digits change on one edge.
- Load 13:05:00 with `mode_12h`=1: `hour_bcd`=0x01, `pm`=1. With `mode_12h`=0 on the same stored time, `hour_bcd`=0x13.
- Load 24:00:00, then 12:60:00, then 0x1A in `set_ss`: three `set_err` pulses, time unchanged, `set_ready` low exactly one cycle after each accept.
- Commit timed onto an advance edge: loaded value appears exactly, no `sec_tick`, and the next tick comes TICK_DIV cycles later.
- Drop `run` for 10 cycles mid-second: time and `pcnt` hold. Then assert `rst` during CHECK: outputs return to reset values and no commit occurs.
